// File: rtl/hamming_pkg.sv
// Shared Hamming SECDED helpers: code geometry and data-bit placement.
// The matching encoder uses the same mapping so both ends agree on bit order.
package hamming_pkg;

  function automatic int unsigned calc_n(input int unsigned r);
    return (32'd1 << r) - 32'd1;
  endfunction

  function automatic int unsigned calc_k(input int unsigned r);
    return (32'd1 << r) - 32'd1 - r;
  endfunction

  // Codeword position (1..N) carrying data bit idx. Powers of two hold parity bits.
  function automatic int unsigned data_pos(input int unsigned r, input int unsigned idx);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned p = 1; p < 64; p++) begin
      if ((p < (32'd1 << r)) && ((p & (p - 32'd1)) != 0)) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_sindrome.sv
// Combinational syndrome and overall-parity generator for an extended Hamming codeword.
module hamming_sindrome
  import hamming_pkg::*;
#(
  parameter int unsigned R = 4,
  localparam int unsigned N = calc_n(R)
) (
  input  logic [N:0]   codeword,
  output logic [R-1:0] s,
  output logic         p
);

  always_comb begin
    s = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      if (codeword[i]) s = s ^ i[R-1:0];
    end
    p = ^codeword;
  end

endmodule

// File: rtl/corrige_hamming_secded.sv
// Two-stage SECDED decoder with valid/ready handshake and saturating error counters.
module corrige_hamming_secded
  import hamming_pkg::*;
#(
  parameter int unsigned R     = 4,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned N    = calc_n(R),
  localparam int unsigned K    = calc_k(R)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N:0]       entrada,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [K-1:0]     saida,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_corr,
  output logic             err_unc,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_unc
);

  logic [R-1:0]     s_comb;
  logic             p_comb;
  logic             s1_full_q;
  logic [N:0]       s1_cw_q;
  logic [R-1:0]     s1_s_q;
  logic             s1_p_q;
  logic             s2_full_q;
  logic [K-1:0]     saida_q, saida_d;
  logic             err_corr_q, err_corr_d;
  logic             err_unc_q, err_unc_d;
  logic [CNT_W-1:0] cnt_corr_q, cnt_unc_q;
  logic [N:0]       corrected;
  logic             s2_ready, s1_adv, in_fire, out_fire;

  hamming_sindrome #(.R(R)) u_sindrome (
    .codeword (entrada),
    .s        (s_comb),
    .p        (p_comb)
  );

  assign s2_ready = !s2_full_q || out_ready;
  assign s1_adv   = s1_full_q && s2_ready;
  assign in_ready = !s1_full_q || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_full_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full_q <= 1'b0;
      s1_cw_q   <= '0;
      s1_s_q    <= '0;
      s1_p_q    <= 1'b0;
    end else begin
      if (in_ready) s1_full_q <= in_valid;
      if (in_fire) begin
        s1_cw_q <= entrada;
        s1_s_q  <= s_comb;
        s1_p_q  <= p_comb;
      end
    end
  end

  // Odd parity means a single flip; a nonzero syndrome then names the bad position.
  always_comb begin
    corrected = s1_cw_q;
    if ((s1_s_q != '0) && s1_p_q) corrected[s1_s_q] = ~s1_cw_q[s1_s_q];
    saida_d = '0;
    for (int unsigned i = 0; i < K; i++) begin
      saida_d[i] = corrected[data_pos(R, i)];
    end
    err_corr_d = s1_p_q;
    err_unc_d  = (s1_s_q != '0) && !s1_p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_full_q  <= 1'b0;
      saida_q    <= '0;
      err_corr_q <= 1'b0;
      err_unc_q  <= 1'b0;
    end else begin
      if (s2_ready) s2_full_q <= s1_full_q;
      if (s1_adv) begin
        saida_q    <= saida_d;
        err_corr_q <= err_corr_d;
        err_unc_q  <= err_unc_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr_q <= '0;
      cnt_unc_q  <= '0;
    end else if (clr_cnt) begin
      cnt_corr_q <= '0;
      cnt_unc_q  <= '0;
    end else if (out_fire) begin
      if (err_corr_q && (cnt_corr_q != {CNT_W{1'b1}})) cnt_corr_q <= cnt_corr_q + 1'b1;
      if (err_unc_q && (cnt_unc_q != {CNT_W{1'b1}}))   cnt_unc_q  <= cnt_unc_q + 1'b1;
    end
  end

  assign saida     = saida_q;
  assign out_valid = s2_full_q;
  assign err_corr  = err_corr_q;
  assign err_unc   = err_unc_q;
  assign cnt_corr  = cnt_corr_q;
  assign cnt_unc   = cnt_unc_q;

endmodule

// File: tb/tb_corrige_hamming_secded.sv
// Self-checking bench: nearest-codeword reference model plus directed SECDED vectors.
module tb_corrige_hamming_secded;

  logic        clk;
  logic        rst_n;
  logic [15:0] entrada;
  logic        in_valid, in_ready, in_ready2;
  logic [10:0] saida, saida2;
  logic        out_valid, out_valid2, out_ready;
  logic        err_corr, err_unc, err_corr2, err_unc2;
  logic        clr_cnt;
  logic [15:0] cnt_corr, cnt_unc;
  logic [1:0]  cnt_corr2, cnt_unc2;

  corrige_hamming_secded #(.R(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .entrada(entrada), .in_valid(in_valid), .in_ready(in_ready),
    .saida(saida), .out_valid(out_valid), .out_ready(out_ready), .err_corr(err_corr),
    .err_unc(err_unc), .clr_cnt(clr_cnt), .cnt_corr(cnt_corr), .cnt_unc(cnt_unc)
  );

  corrige_hamming_secded #(.R(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .entrada(entrada), .in_valid(in_valid), .in_ready(in_ready2),
    .saida(saida2), .out_valid(out_valid2), .out_ready(out_ready), .err_corr(err_corr2),
    .err_unc(err_unc2), .clr_cnt(clr_cnt), .cnt_corr(cnt_corr2), .cnt_unc(cnt_unc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] d;
    logic        c;
    logic        u;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   delivered = 0;
  int   m_corr = 0, m_unc = 0, m_corr2 = 0, m_unc2 = 0;
  logic        stall_prev = 1'b0;
  logic [10:0] saida_prev;
  logic        corr_prev, unc_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_data(input int p);
    return (p & (p - 1)) != 0;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] cw);
    logic [10:0] d;
    int idx;
    d = '0;
    idx = 0;
    for (int p = 1; p < 16; p++) begin
      if (is_data(p)) begin
        d[idx] = cw[p];
        idx++;
      end
    end
    return d;
  endfunction

  // Parity bit 2^j covers every position whose index has bit j set.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] cw;
    int idx;
    cw = '0;
    idx = 0;
    for (int p = 1; p < 16; p++) begin
      if (is_data(p)) begin
        cw[p] = d[idx];
        idx++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p < 16; p++) begin
        if (is_data(p) && (((p >> j) & 1) == 1)) par = par ^ cw[p];
      end
      cw[1 << j] = par;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  // Valid codeword: clean; one flip away from valid: corrected; otherwise uncorrectable.
  function automatic exp_t model_decode(input logic [15:0] cw);
    exp_t e;
    logic [15:0] t;
    e.d = extract(cw);
    e.c = 1'b0;
    e.u = 1'b0;
    if (encode(extract(cw)) == cw) return e;
    for (int i = 0; i < 16; i++) begin
      t = cw;
      t[i] = ~t[i];
      if (encode(extract(t)) == t) begin
        e.d = extract(t);
        e.c = 1'b1;
        return e;
      end
    end
    e.u = 1'b1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_corr = 0; m_unc = 0; m_corr2 = 0; m_unc2 = 0;
      stall_prev = 1'b0;
    end else begin
      exp_t e;
      chk("cnt_corr", {16'b0, cnt_corr}, m_corr);
      chk("cnt_unc", {16'b0, cnt_unc}, m_unc);
      chk("cnt_corr_w2", {30'b0, cnt_corr2}, m_corr2);
      chk("cnt_unc_w2", {30'b0, cnt_unc2}, m_unc2);
      if (stall_prev) begin
        chk("stall_valid", {31'b0, out_valid}, 1);
        chk("stall_saida", {21'b0, saida}, {21'b0, saida_prev});
        chk("stall_flags", {30'b0, err_corr, err_unc}, {30'b0, corr_prev, unc_prev});
      end
      stall_prev = out_valid && !out_ready;
      saida_prev = saida;
      corr_prev  = err_corr;
      unc_prev   = err_unc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", {31'b0, out_valid}, 0);
        end else begin
          e = exp_q.pop_front();
          delivered++;
          chk("saida", {21'b0, saida}, {21'b0, e.d});
          chk("saida_w2", {21'b0, saida2}, {21'b0, e.d});
          chk("err_corr", {31'b0, err_corr}, {31'b0, e.c});
          chk("err_unc", {31'b0, err_unc}, {31'b0, e.u});
          if (e.c) begin
            if (m_corr < 65535) m_corr++;
            if (m_corr2 < 3) m_corr2++;
          end
          if (e.u) begin
            if (m_unc < 65535) m_unc++;
            if (m_unc2 < 3) m_unc2++;
          end
        end
      end
      if (clr_cnt) begin
        m_corr = 0; m_unc = 0; m_corr2 = 0; m_unc2 = 0;
      end
      if (in_valid && in_ready) exp_q.push_back(model_decode(entrada));
    end
  end

  task automatic send(input logic [15:0] cw);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    entrada = cw;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", {31'b0, in_ready}, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    if (i == 50) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Hold the word at the output and check it against literal expectations.
  task automatic send_hold(input logic [15:0] cw, input logic [10:0] d, input logic c,
                           input logic u);
    int i;
    out_ready = 1'b0;
    send(cw);
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("hold_valid", {31'b0, out_valid}, 1);
    chk("hold_saida", {21'b0, saida}, {21'b0, d});
    chk("hold_flags", {30'b0, err_corr, err_unc}, {30'b0, c, u});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
  endtask

  logic [10:0] stream_d [8] = '{11'h000, 11'h7FF, 11'h123, 11'h456,
                                11'h0AA, 11'h555, 11'h3C3, 11'h1F0};

  initial begin
    logic [15:0] cw;
    logic saw_low;
    int base;
    exp_t pe;
    rst_n = 1'b0; in_valid = 1'b0; entrada = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_saida", {21'b0, saida}, 0);
    chk("rst_cnts", {cnt_corr, cnt_unc}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 1);

    chk("pin_encode", {16'b0, encode(11'h5A3)}, 32'h0000B42D);
    pe = model_decode(16'hB405);
    chk("pin_model_unc", {20'b0, pe.d, pe.u}, {20'b0, 11'h5A0, 1'b1});
    pe = model_decode(16'hB40D);
    chk("pin_model_corr", {20'b0, pe.d, pe.c}, {20'b0, 11'h5A3, 1'b1});

    // Latency: accept on one edge, out_valid visible two edges later.
    @(posedge clk);
    #1 in_valid = 1'b1; entrada = 16'hB42D;
    @(negedge clk);
    chk("lat_accept", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", {31'b0, out_valid}, 0);
    @(negedge clk);
    chk("lat_cycle2", {31'b0, out_valid}, 1);
    chk("lat_saida", {21'b0, saida}, 32'h5A3);
    chk("lat_flags", {30'b0, err_corr, err_unc}, 0);
    drain();
    chk("clean_cnt", {cnt_corr, cnt_unc}, 0);

    send_hold(16'hB40D, 11'h5A3, 1'b1, 1'b0);
    chk("single_cnt", {16'b0, cnt_corr}, 1);
    send_hold(16'hB405, 11'h5A0, 1'b0, 1'b1);
    chk("double_cnt", {16'b0, cnt_unc}, 1);
    send_hold(16'hB42C, 11'h5A3, 1'b1, 1'b0);
    chk("parity_cnt", {16'b0, cnt_corr}, 2);

    // Back-to-back stream with a three-cycle output stall.
    base = delivered;
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          cw = encode(stream_d[i]);
          if (i % 3 == 1) cw[i + 1] = ~cw[i + 1];
          if (i % 3 == 2) begin
            cw[i] = ~cw[i];
            cw[i + 7] = ~cw[i + 7];
          end
          send(cw);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        repeat (15) begin
          @(negedge clk);
          if (!in_ready) saw_low = 1'b1;
        end
      end
    join
    drain();
    chk("stream_backpressure", {31'b0, saw_low}, 1);
    chk("stream_delivered", delivered - base, 8);

    // Saturation of the 2-bit counter, then clear racing an increment.
    repeat (5) send(16'hB40D);
    drain();
    chk("sat_w2", {30'b0, cnt_corr2}, 3);
    out_ready = 1'b0;
    send(16'hB40D);
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    @(posedge clk);
    #1 clr_cnt = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_wins", {16'b0, cnt_corr}, 0);
    chk("clr_wins_w2", {30'b0, cnt_corr2}, 0);
    drain();

    // Reset mid-stream with two words in flight.
    send(16'hB42D);
    send(encode(11'h123));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 0);
    chk("midrst_in_ready", {31'b0, in_ready}, 1);
    chk("midrst_saida", {21'b0, saida}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", {31'b0, in_ready}, 1);
    repeat (5) begin
      @(negedge clk);
      chk("no_stale", {31'b0, out_valid}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/corrige_hamming_secded.md
CORRIGE_HAMMING_SECDED -- requirements
Module: corrige_hamming_secded

Interface
REQ-001 SHALL have parameter R, default 4: Hamming parity-bit count, legal 3..6; N = 2^R-1, K = N-R.
REQ-002 SHALL have parameter CNT_W, default 16: width of the error counters, legal 2..32.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 entrada  input  N+1  SECDED codeword; bit 0 = overall parity; bit p (1..N) = Hamming position p.
REQ-007 in_valid  input  1  entrada valid.
REQ-008 in_ready  output  1  block accepts entrada this cycle.
REQ-009 saida  output  K  decoded data word.
REQ-010 out_valid  output  1  saida/flags valid.
REQ-011 out_ready  input  1  downstream accepts saida.
REQ-012 err_corr  output  1  word had a single-bit error, corrected.
REQ-013 err_unc  output  1  word had a double-bit error, uncorrectable.
REQ-014 clr_cnt  input  1  synchronous clear of both counters.
REQ-015 cnt_corr  output  CNT_W  saturating count of delivered err_corr words.
REQ-016 cnt_unc  output  CNT_W  saturating count of delivered err_unc words.

Function
REQ-017 Syndrome s SHALL be the XOR of indices p (1..N) where entrada[p]=1; P SHALL be the XOR of all N+1 bits.
REQ-018 s=0, P=0: no error; data passed, both flags 0.
REQ-019 s!=0, P=1: bit s inverted before extraction; err_corr=1.
REQ-020 s=0, P=1: overall parity bit in error; data unchanged; err_corr=1.
REQ-021 s!=0, P=0: data passed uncorrected; err_unc=1, err_corr=0.
REQ-022 saida SHALL be the K non-power-of-two positions in ascending order, lowest position to saida[0].
REQ-023 Two-stage pipeline: stage 1 registers codeword, s, P; stage 2 registers saida and flags; latency exactly 2 cycles from accept to out_valid with out_ready held high.
REQ-024 Throughput SHALL be one word per cycle with no bubbles when out_ready=1.
REQ-025 Transfer occurs on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-026 Each stage SHALL load when empty or when its content moves on the same cycle; in_ready = !s1_full || s1_advances (combinational, no in_valid dependency).
REQ-027 While out_valid=1 and out_ready=0, saida, err_corr, err_unc SHALL stay stable; no word lost or duplicated.
REQ-028 Counters SHALL increment only on output transfer of a flagged word; saturate at 2^CNT_W-1.
REQ-029 clr_cnt asserted concurrently with an increment: clear wins; counter = 0 next cycle.

Reset
REQ-030 rst_n low SHALL asynchronously force out_valid=0, saida=0, err_corr=0, err_unc=0, cnt_corr=0, cnt_unc=0, both stages empty.
REQ-031 in_ready SHALL be 1 during reset and in the first cycle after release; in-flight words discarded when reset occurs mid-stream.

Structure
REQ-032 Package hamming_pkg SHALL hold N/K derivation functions and a data-position mapping function shared with the matching encoder.
REQ-033 One combinational sub-module hamming_sindrome (inputs codeword, outputs s, P) SHALL be instantiated in stage 1.
REQ-034 No memories or multicycle paths; all state flops reset by rst_n.

Verification (R=4, CNT_W=16 unless noted)
REQ-035 Encoded data 11'h5A3 sent clean -> saida=11'h5A3 exactly 2 cycles later, flags 0, counters unchanged.
REQ-036 Same codeword with entrada[5] flipped -> saida=11'h5A3, err_corr=1, cnt_corr=1 after transfer.
REQ-037 Codeword with bits 3 and 5 flipped -> err_unc=1, err_corr=0, cnt_unc=1; codeword with bit 0 flipped -> saida correct, err_corr=1.
REQ-038 Stream of 8 back-to-back words, out_ready low cycles 3-5 -> in_ready drops after both stages fill, outputs stable while stalled, all 8 delivered in order.
REQ-039 CNT_W=2, 5 single-error words -> cnt_corr saturates at 3; clr_cnt with simultaneous flagged transfer -> 0.
REQ-040 rst_n pulsed low mid-stream with 2 words in flight -> out_valid=0 immediately, no stale word emitted after release.
